// File: rtl/seq_pkg.sv
// Shared definitions for the program-counter sequencer: opcodes, FSM states,
// C_bus source encodings and the state-to-output decode.
package seq_pkg;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_JMPZ = 8'h10;
  localparam logic [7:0] OP_JMP  = 8'h11;
  localparam logic [7:0] OP_HALT = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESTART,
    ST_FETCH,
    ST_LATCH,
    ST_DECODE,
    ST_EXEC,
    ST_JUMP,
    ST_HALT
  } seq_state_e;

  typedef enum logic [1:0] {
    CB_NONE = 2'd0,
    CB_JUMP = 2'd1,
    CB_ZERO = 2'd2
  } cbus_sel_e;

  typedef struct packed {
    logic      pc_enable;
    logic      pc_load;
    logic      pc_inc;
    logic      pc_finish;
    cbus_sel_e cbus_sel;
    logic      iram_rd;
    logic      ir_load;
    logic      busy;
    logic      halted;
  } seq_out_t;

  // Moore decode; registered by the caller against the next state.
  function automatic seq_out_t state_outputs(input seq_state_e st);
    seq_out_t o;
    o.pc_enable = st inside {ST_RESTART, ST_FETCH, ST_LATCH, ST_DECODE, ST_EXEC, ST_JUMP};
    o.pc_load   = st inside {ST_RESTART, ST_JUMP};
    o.pc_inc    = (st == ST_LATCH);
    o.pc_finish = (st == ST_HALT);
    o.cbus_sel  = (st == ST_RESTART) ? CB_ZERO :
                  (st == ST_JUMP)    ? CB_JUMP : CB_NONE;
    o.iram_rd   = (st == ST_FETCH);
    o.ir_load   = (st == ST_LATCH);
    o.busy      = !(st inside {ST_IDLE, ST_HALT});
    o.halted    = (st == ST_HALT);
    return o;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/data bundle between the sequencer and the PC, IRAM and datapath.
// Handshake: exec_start is a one-cycle request; exec_done completes it and is
// only honoured while the sequencer is in EXEC, including the start cycle.
interface pc_sequencer_if #(parameter int OPW = 8);
  logic           start;
  logic [OPW-1:0] instr;
  logic           z_flag;
  logic           exec_done;
  logic           pc_enable;
  logic           pc_load;
  logic           pc_inc;
  logic           pc_finish;
  logic [1:0]     cbus_sel;
  logic           iram_rd;
  logic           ir_load;
  logic [OPW-1:0] op_code;
  logic           exec_start;
  logic           busy;
  logic           halted;

  modport master (
    input  start, instr, z_flag, exec_done,
    output pc_enable, pc_load, pc_inc, pc_finish, cbus_sel,
           iram_rd, ir_load, op_code, exec_start, busy, halted
  );

  modport slave (
    output start, instr, z_flag, exec_done,
    input  pc_enable, pc_load, pc_inc, pc_finish, cbus_sel,
           iram_rd, ir_load, op_code, exec_start, busy, halted
  );
endinterface

// File: rtl/pc_sequencer_op_decode.sv
// Combinational opcode classifier; exactly one output is high for any opcode.
module op_decode
  import seq_pkg::*;
#(
  parameter int OPW = 8
) (
  input  logic [OPW-1:0] op,
  output logic           is_halt,
  output logic           is_jmp,
  output logic           is_jmpz,
  output logic           is_nop,
  output logic           is_exec
);

  assign is_halt = (op == OPW'(OP_HALT));
  assign is_jmp  = (op == OPW'(OP_JMP));
  assign is_jmpz = (op == OPW'(OP_JMPZ));
  assign is_nop  = (op == OPW'(OP_NOP));
  assign is_exec = !(is_halt || is_jmp || is_jmpz || is_nop);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch/latch/decode loop driving PC controls and
// handing datapath opcodes off through the exec_start/exec_done handshake.
module pc_sequencer
  import seq_pkg::*;
#(
  parameter int OPW     = 8,
  parameter int MEM_LAT = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  pc_sequencer_if.master  bus,
  output seq_state_e      state_dbg
);

  localparam logic [3:0] LAT_RELOAD = 4'(MEM_LAT - 1);

  seq_state_e     state_q, state_d;
  logic [3:0]     lat_cnt_q;
  logic [OPW-1:0] op_code_q;
  seq_out_t       out_q;
  logic           exec_start_q;

  logic is_halt, is_jmp, is_jmpz, is_nop, is_exec;

  op_decode #(.OPW(OPW)) u_op_decode (
    .op      (op_code_q),
    .is_halt (is_halt),
    .is_jmp  (is_jmp),
    .is_jmpz (is_jmpz),
    .is_nop  (is_nop),
    .is_exec (is_exec)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (bus.start) state_d = ST_RESTART;
      ST_RESTART: state_d = ST_FETCH;
      ST_FETCH:   if (lat_cnt_q == 4'd0) state_d = ST_LATCH;
      ST_LATCH:   state_d = ST_DECODE;
      ST_DECODE: begin
        if (is_halt)      state_d = ST_HALT;
        else if (is_jmp)  state_d = ST_JUMP;
        else if (is_jmpz) state_d = bus.z_flag ? ST_JUMP : ST_FETCH;
        else if (is_nop)  state_d = ST_FETCH;
        else if (is_exec) state_d = ST_EXEC;
        else              state_d = ST_FETCH;
      end
      ST_EXEC:    if (bus.exec_done) state_d = ST_FETCH;
      ST_JUMP:    state_d = ST_FETCH;
      ST_HALT:    if (bus.start) state_d = ST_RESTART;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      lat_cnt_q    <= 4'd0;
      op_code_q    <= '0;
      out_q        <= '0;
      exec_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_q        <= state_outputs(state_d);
      exec_start_q <= (state_d == ST_EXEC) && (state_q != ST_EXEC);
      if (state_q == ST_LATCH) op_code_q <= bus.instr;
      if ((state_d == ST_FETCH) && (state_q != ST_FETCH))
        lat_cnt_q <= LAT_RELOAD;
      else if ((state_q == ST_FETCH) && (lat_cnt_q != 4'd0))
        lat_cnt_q <= lat_cnt_q - 4'd1;
    end
  end

  assign bus.pc_enable  = out_q.pc_enable;
  assign bus.pc_load    = out_q.pc_load;
  assign bus.pc_inc     = out_q.pc_inc;
  assign bus.pc_finish  = out_q.pc_finish;
  assign bus.cbus_sel   = out_q.cbus_sel;
  assign bus.iram_rd    = out_q.iram_rd;
  assign bus.ir_load    = out_q.ir_load;
  assign bus.busy       = out_q.busy;
  assign bus.halted     = out_q.halted;
  assign bus.exec_start = exec_start_q;
  assign bus.op_code    = op_code_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a small PC + IRAM model around it.
module tb_pc_sequencer;
  import seq_pkg::*;

  logic       clk;
  logic       rst_n;
  seq_state_e state_dbg;
  int         checks;
  int         errors;

  pc_sequencer_if #(.OPW(8)) bus ();

  pc_sequencer #(.OPW(8), .MEM_LAT(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC and IRAM model
  logic [7:0] iram [256];
  logic [7:0] pc_q;
  logic [7:0] jump_target;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= 8'h00;
    else if (bus.pc_enable && bus.pc_load)
      pc_q <= (bus.cbus_sel == 2'd2) ? 8'h00 : jump_target;
    else if (bus.pc_enable && bus.pc_inc)
      pc_q <= pc_q + 8'h01;
  end

  assign bus.instr = iram[pc_q];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_n(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // pc_load and pc_inc must never coincide
  always @(negedge clk) begin
    checks++;
    assert (!(bus.pc_load === 1'b1 && bus.pc_inc === 1'b1)) else begin
      errors++;
      $error("FAIL load_inc_excl: observed=%0h expected=%0h", {bus.pc_load, bus.pc_inc}, 2'b00);
    end
  end

  function automatic logic [31:0] all_outs();
    return {16'h0, bus.pc_enable, bus.pc_load, bus.pc_inc, bus.pc_finish, bus.cbus_sel,
            bus.iram_rd, bus.ir_load, bus.exec_start, bus.busy, bus.halted, 5'b0} | 32'(bus.op_code);
  endfunction

  initial begin
    int inc_n, first_inc, last_inc, es_cnt, rs;
    logic spacing_ok;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.z_flag = 1'b0;
    bus.exec_done = 1'b0;
    jump_target = 8'h08;
    for (int i = 0; i < 256; i++) iram[i] = 8'hFF;

    // reset state
    wait_n(2);
    chk("reset_outs", all_outs(), 32'h0);
    chk("reset_state", 32'(state_dbg), 32'(ST_IDLE));
    rst_n = 1'b1;

    // NOP, NOP, HALT
    iram[0] = 8'h00; iram[1] = 8'h00; iram[2] = 8'hFF;
    tick();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    chk("restart_load", 32'(bus.pc_load), 32'd1);
    chk("restart_cbus", 32'(bus.cbus_sel), 32'd2);
    chk("restart_en", 32'(bus.pc_enable), 32'd1);
    tick();
    chk("first_iram_rd", 32'(bus.iram_rd), 32'd1);
    inc_n = 0; first_inc = 0; last_inc = 0; spacing_ok = 1'b1;
    for (int k = 2; k <= 13; k++) begin
      if (bus.pc_inc) begin
        if (inc_n > 0 && (k - last_inc) != 4) spacing_ok = 1'b0;
        if (inc_n == 0) first_inc = k;
        last_inc = k;
        inc_n++;
      end
      tick();
    end
    chk("inc_count", 32'(inc_n), 32'd3);
    chk("inc_first", 32'(first_inc), 32'd4);
    chk("inc_spacing", 32'(spacing_ok), 32'd1);
    chk("halt_halted", 32'(bus.halted), 32'd1);
    chk("halt_finish", 32'(bus.pc_finish), 32'd1);
    chk("halt_en", 32'(bus.pc_enable), 32'd0);
    chk("halt_busy", 32'(bus.busy), 32'd0);
    chk("halt_opcode", 32'(bus.op_code), 32'hFF);

    // JMPZ taken
    iram[0] = 8'h10; iram[1] = 8'hFF; iram[8] = 8'hFF;
    bus.z_flag = 1'b1;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    wait_n(4);
    chk("jz_decode", 32'(state_dbg), 32'(ST_DECODE));
    tick();
    chk("jz_t_load", 32'(bus.pc_load), 32'd1);
    chk("jz_t_cbus", 32'(bus.cbus_sel), 32'd1);
    chk("jz_t_inc", 32'(bus.pc_inc), 32'd0);
    bus.z_flag = 1'b0;
    wait_n(5);
    chk("jz_t_halt", 32'(bus.halted), 32'd1);

    // JMPZ untaken
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    wait_n(5);
    chk("jz_u_rd", 32'(bus.iram_rd), 32'd1);
    chk("jz_u_load", 32'(bus.pc_load), 32'd0);
    wait_n(4);
    chk("jz_u_halt", 32'(bus.halted), 32'd1);

    // datapath op, exec_done after 5 cycles
    iram[0] = 8'h42; iram[1] = 8'hFF;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    wait_n(5);
    chk("ex_start", 32'(bus.exec_start), 32'd1);
    chk("ex_opcode", 32'(bus.op_code), 32'h42);
    es_cnt = 1;
    for (int k = 7; k <= 11; k++) begin
      tick();
      es_cnt += int'(bus.exec_start);
    end
    chk("ex_wait_state", 32'(state_dbg), 32'(ST_EXEC));
    bus.exec_done = 1'b1; tick(); bus.exec_done = 1'b0;
    chk("ex_start_once", 32'(es_cnt), 32'd1);
    chk("ex_resume_rd", 32'(bus.iram_rd), 32'd1);
    chk("ex_resume_es", 32'(bus.exec_start), 32'd0);
    wait_n(4);
    chk("ex_halt", 32'(bus.halted), 32'd1);

    // datapath op, exec_done with exec_start
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    wait_n(5);
    chk("ex0_start", 32'(bus.exec_start), 32'd1);
    bus.exec_done = 1'b1; tick(); bus.exec_done = 1'b0;
    chk("ex0_resume_rd", 32'(bus.iram_rd), 32'd1);
    chk("ex0_es_low", 32'(bus.exec_start), 32'd0);
    chk("ex0_state", 32'(state_dbg), 32'(ST_FETCH));
    wait_n(4);
    chk("ex0_halt", 32'(bus.halted), 32'd1);

    // reset in the middle of EXEC
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    wait_n(6);
    chk("rst_pre_state", 32'(state_dbg), 32'(ST_EXEC));
    rst_n = 1'b0;
    #1;
    chk("rst_async_outs", all_outs(), 32'h0);
    chk("rst_async_state", 32'(state_dbg), 32'(ST_IDLE));
    #2 rst_n = 1'b1;
    tick();
    bus.exec_done = 1'b1; wait_n(2); bus.exec_done = 1'b0;
    chk("stray_done_state", 32'(state_dbg), 32'(ST_IDLE));
    chk("stray_done_busy", 32'(bus.busy), 32'd0);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    chk("rst_restart", 32'(state_dbg), 32'(ST_RESTART));
    wait_n(5);
    bus.exec_done = 1'b1; tick(); bus.exec_done = 1'b0;
    wait_n(4);
    chk("rst_run_halt", 32'(bus.halted), 32'd1);

    // start pulses while busy are ignored
    iram[0] = 8'h00; iram[1] = 8'h00; iram[2] = 8'hFF;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    tick();
    rs = 0;
    for (int k = 2; k <= 13; k++) begin
      if (bus.pc_load && bus.cbus_sel == 2'd2) rs++;
      bus.start = (k == 3 || k == 8);
      tick();
    end
    bus.start = 1'b0;
    chk("busy_start_ign", 32'(rs), 32'd0);
    chk("busy_halt", 32'(bus.halted), 32'd1);

    // start held in HALT restarts once
    iram[0] = 8'hFF;
    bus.start = 1'b1;
    rs = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (bus.pc_load && bus.cbus_sel == 2'd2) rs++;
      if (k == 3) bus.start = 1'b0;
    end
    chk("held_restart_once", 32'(rs), 32'd1);
    chk("held_halt", 32'(bus.halted), 32'd1);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Instruction-sequencing controller for the down-sampling processor's program counter. It drives the PC's `enable`/`load`/`inc`/`finish` controls and fetches from instruction RAM. It latches and decodes each opcode, then hands non-control opcodes to the datapath with a start/done handshake. It sits between the PC, the IRAM, and the datapath control, and is the only block that writes PC control inputs.

## Interface
Parameters:
- `OPW`, 8, opcode width (equals IRAM data width).
- `MEM_LAT`, 2, IRAM read latency in cycles; legal range 1–15.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  run request; sampled in IDLE and HALT only.
- `instr`  in  OPW  IRAM read data; valid `MEM_LAT` cycles after `iram_rd` rises.
- `z_flag`  in  1  datapath zero flag.
- `exec_done`  in  1  datapath op complete.
- `pc_enable`  out  1  PC enable.
- `pc_load`  out  1  PC loads from C_bus this cycle.
- `pc_inc`  out  1  PC increments this cycle.
- `pc_finish`  out  1  program finished.
- `cbus_sel`  out  2  C_bus source request: 0 none, 1 jump target, 2 zero.
- `iram_rd`  out  1  IRAM read strobe.
- `ir_load`  out  1  instruction-register latch strobe.
- `op_code`  out  OPW  registered opcode to the datapath.
- `exec_start`  out  1  one-cycle datapath start pulse.
- `busy`  out  1  high in every state except IDLE and HALT.
- `halted`  out  1  high in HALT.

## Operation
Opcodes:
- NOP 0x00
- JMP 0x11
- JMPZ 0x10
- HALT 0xFF
- All other values are datapath ops.

States:
- IDLE: all outputs low. If `start` is high → RESTART.
- RESTART (1 cycle): `pc_enable`=1, `pc_load`=1, `cbus_sel`=2, so the PC is loaded with 0. → FETCH.
- FETCH (`MEM_LAT` cycles): `iram_rd`=1 and the latency counter counts down. When the count expires → LATCH.
- LATCH (1 cycle): `ir_load`=1, `pc_inc`=1. `op_code` is registered from `instr`. → DECODE.
- DECODE (1 cycle), branching on `op_code`:
  - HALT → HALT.
  - JMP → JUMP.
  - JMPZ with `z_flag`=1 → JUMP.
  - JMPZ with `z_flag`=0 → FETCH.
  - NOP → FETCH.
  - Anything else → EXEC.
- EXEC: `exec_start`=1 on the first cycle only. Stays until `exec_done`=1, then → FETCH.
- JUMP (1 cycle): `pc_load`=1, `cbus_sel`=1. → FETCH.
- HALT: `pc_finish`=1, `halted`=1, `pc_enable`=0. If `start` is high → RESTART.

Output rules:
- `pc_enable`=1 in RESTART, FETCH, LATCH, DECODE, EXEC and JUMP.
- `pc_load` and `pc_inc` are never high in the same cycle.
- All outputs are registered and state-decoded, with no combinational path from inputs.

## Timing
- Reset: state IDLE; every output 0, `op_code`=0, counter=0.
- `rst_n` low mid-operation: immediate return to IDLE. Any pending `exec_done` is discarded.
- Latency:
  - `start` → first `iram_rd`: 2 cycles.
  - NOP or untaken JMPZ: `MEM_LAT`+2 cycles per instruction.
  - Taken jump: `MEM_LAT`+3 cycles.
  - Datapath op: `MEM_LAT`+3+(cycles until `exec_done`).
- `exec_done` in the same cycle as `exec_start` is accepted; EXEC then lasts exactly 1 cycle.
- `exec_done` outside EXEC is ignored.
- `start` while `busy` is ignored.
- `start` held high through HALT→RESTART causes a restart once per entry into HALT. There is no re-trigger while busy.
- `z_flag` is sampled only in DECODE.
- PC address wrap (0xFF→0x00) belongs to the PC. The sequencer continues fetching normally.
- The latency counter reloads to `MEM_LAT`−1 on every entry into FETCH.

## Structure
- Shared package `seq_pkg`:
  - opcode constants NOP, JMP, JMPZ and HALT;
  - the state enum;
  - the `cbus_sel` encodings (CB_NONE, CB_JUMP, CB_ZERO).
- Sub-module `op_decode`: a combinational opcode classifier with outputs is_halt, is_jmp, is_jmpz, is_nop and is_exec. It is instantiated once and feeds the DECODE transition.
- The FSM, latency counter and output registers sit in `pc_sequencer`.

## Test plan
- Reset, then `start` pulse with IRAM program {0x00, 0x00, 0xFF} and `MEM_LAT`=2:
  - `pc_load` with `cbus_sel`=2 on cycle 1;
  - `pc_inc` pulses exactly 3 times, at 4-cycle spacing;
  - then `halted`=1, `pc_finish`=1, `pc_enable`=0.
- Program {0x10, …} with `z_flag`=1, then again with `z_flag`=0:
  - taken: JUMP cycle with `pc_load`=1 and `cbus_sel`=1;
  - untaken: `iram_rd` again directly after DECODE, with no `pc_load`.
- Opcode 0x42 with `exec_done` delayed by 5 cycles, then with `exec_done` in the same cycle as `exec_start`:
  - `exec_start` is high for exactly 1 cycle in both runs;
  - `op_code`=0x42;
  - FETCH resumes on the cycle after `exec_done`.
- `rst_n` asserted in the middle of EXEC:
  - all outputs go to 0 asynchronously;
  - after release, a stray `exec_done` causes no transition and `start` restarts cleanly.
- `start` pulses while `busy`, and `start` held high in HALT:
  - the pulses while `busy` are ignored;
  - held high in HALT gives exactly one RESTART.
- Over all scenarios, an assertion checks that `pc_load` and `pc_inc` are never both high.
